// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the 2-way set-associative data cache.
package dcache_pkg;

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_MISS        = 3'd1,
      S_WRITEBACK   = 3'd2,
      S_REFILL      = 3'd3,
      S_REFILL_DONE = 3'd4
   } state_e;

   function automatic int off_w(input int line_bytes);
      return $clog2(line_bytes);
   endfunction

   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(input int addr_w, input int line_bytes, input int sets);
      return addr_w - $clog2(sets) - $clog2(line_bytes);
   endfunction

endpackage

// File: rtl/dcache_way.sv
// One cache way: tag/data arrays with async read and sync write, valid/dirty
// bits cleared by reset, and the tag-match comparator for the addressed set.
module dcache_way
   import dcache_pkg::*;
#(
   parameter int IDX_W  = 4,
   parameter int TAG_W  = 23,
   parameter int LINE_W = 256
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic [TAG_W-1:0]  tag_i,
   input  logic              wr_en_i,
   input  logic [LINE_W-1:0] wr_data_i,
   input  logic              wr_dirty_i,
   output logic              hit_o,
   output logic              valid_o,
   output logic              dirty_o,
   output logic [TAG_W-1:0]  tag_o,
   output logic [LINE_W-1:0] data_o
);

   localparam int SETS = 1 << IDX_W;

   logic [TAG_W-1:0]  tag_q  [SETS];
   logic [LINE_W-1:0] data_q [SETS];
   logic [SETS-1:0]   valid_q, valid_d;
   logic [SETS-1:0]   dirty_q, dirty_d;

   always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      if (wr_en_i) begin
         valid_d[idx_i] = 1'b1;
         dirty_d[idx_i] = wr_dirty_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   // Tag and data contents are meaningless until valid is set, so no reset here.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         tag_q[idx_i]  <= tag_i;
         data_q[idx_i] <= wr_data_i;
      end
   end

   assign valid_o = valid_q[idx_i];
   assign dirty_o = dirty_q[idx_i];
   assign tag_o   = tag_q[idx_i];
   assign data_o  = data_q[idx_i];
   assign hit_o   = valid_q[idx_i] && (tag_q[idx_i] == tag_i);

endmodule

// File: rtl/dcache_2way_top.sv
// 2-way set-associative write-back, write-allocate L1 data cache with per-set
// LRU replacement; stalls the MEM stage on miss, writes back a dirty victim, then refills.
module dcache_2way_top
   import dcache_pkg::*;
#(
   parameter int  ADDR_W     = 32,
   parameter int  LINE_BYTES = 32,
   parameter int  SETS       = 16,
   localparam int LINE_W     = 8 * LINE_BYTES
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i,
   output logic [LINE_W-1:0] mem_data_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   input  logic [31:0]       p1_data_i,
   input  logic [ADDR_W-1:0] p1_addr_i,
   input  logic              p1_MemRead_i,
   input  logic              p1_MemWrite_i,
   output logic [31:0]       p1_data_o,
   output logic              p1_stall_o
);

   localparam int OFF_W  = off_w(LINE_BYTES);
   localparam int IDX_W  = idx_w(SETS);
   localparam int TAG_W  = tag_w(ADDR_W, LINE_BYTES, SETS);
   localparam int WSEL_W = OFF_W - 2;

   logic              req;
   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic [WSEL_W-1:0] wsel;
   logic              unused_addr_lsb;

   logic [1:0]        way_hit, way_valid, way_dirty, way_wr_en;
   logic [TAG_W-1:0]  way_tag  [2];
   logic [LINE_W-1:0] way_data [2];

   logic              hit, hit_way, wr_dirty;
   logic [LINE_W-1:0] hit_line, wr_line;

   state_e            state_q, state_d;
   logic              victim_q, victim_d;
   logic [SETS-1:0]   lru_q, lru_d;
   logic              mem_enable_q, mem_enable_d;
   logic              mem_write_q, mem_write_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0] mem_data_q, mem_data_d;

   assign req             = p1_MemRead_i | p1_MemWrite_i;
   assign idx             = p1_addr_i[OFF_W +: IDX_W];
   assign tag             = p1_addr_i[ADDR_W-1 -: TAG_W];
   assign wsel            = p1_addr_i[2 +: WSEL_W];
   assign unused_addr_lsb = ^p1_addr_i[1:0];

   for (genvar k = 0; k < 2; k++) begin : g_way
      dcache_way #(
         .IDX_W  (IDX_W),
         .TAG_W  (TAG_W),
         .LINE_W (LINE_W)
      ) u_way (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .idx_i      (idx),
         .tag_i      (tag),
         .wr_en_i    (way_wr_en[k]),
         .wr_data_i  (wr_line),
         .wr_dirty_i (wr_dirty),
         .hit_o      (way_hit[k]),
         .valid_o    (way_valid[k]),
         .dirty_o    (way_dirty[k]),
         .tag_o      (way_tag[k]),
         .data_o     (way_data[k])
      );
   end

   // Hits only count in IDLE so the refilled line is consumed on the cycle after REFILL_DONE.
   assign hit        = (state_q == S_IDLE) && (|way_hit);
   assign hit_way    = ~way_hit[0];
   assign hit_line   = way_data[hit_way];
   assign p1_data_o  = hit ? hit_line[{wsel, 5'd0} +: 32] : 32'h0;
   assign p1_stall_o = req & ~hit;

   always_comb begin
      way_wr_en = '0;
      wr_line   = hit_line;
      wr_dirty  = 1'b0;
      if (hit && p1_MemWrite_i) begin
         way_wr_en[hit_way]          = 1'b1;
         wr_line[{wsel, 5'd0} +: 32] = p1_data_i;
         wr_dirty                    = 1'b1;
      end else if (state_q == S_REFILL && mem_ack_i) begin
         way_wr_en[victim_q] = 1'b1;
         wr_line             = mem_data_i;
      end
   end

   always_comb begin
      lru_d = lru_q;
      if (hit && req) begin
         lru_d[idx] = ~hit_way;
      end
   end

   always_comb begin
      state_d      = state_q;
      victim_d     = victim_q;
      mem_enable_d = mem_enable_q;
      mem_write_d  = mem_write_q;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      case (state_q)
         S_IDLE: begin
            if (req && !hit) begin
               state_d  = S_MISS;
               victim_d = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[idx]);
            end
         end
         S_MISS: begin
            mem_enable_d = 1'b1;
            if (way_valid[victim_q] && way_dirty[victim_q]) begin
               state_d     = S_WRITEBACK;
               mem_write_d = 1'b1;
               mem_addr_d  = {way_tag[victim_q], idx, {OFF_W{1'b0}}};
               mem_data_d  = way_data[victim_q];
            end else begin
               state_d     = S_REFILL;
               mem_write_d = 1'b0;
               mem_addr_d  = {tag, idx, {OFF_W{1'b0}}};
            end
         end
         S_WRITEBACK: begin
            if (mem_ack_i) begin
               state_d     = S_REFILL;
               mem_write_d = 1'b0;
               mem_addr_d  = {tag, idx, {OFF_W{1'b0}}};
            end
         end
         S_REFILL: begin
            if (mem_ack_i) begin
               state_d      = S_REFILL_DONE;
               mem_enable_d = 1'b0;
            end
         end
         S_REFILL_DONE: state_d = S_IDLE;
         default:       state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         victim_q     <= 1'b0;
         lru_q        <= '0;
         mem_enable_q <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         victim_q     <= victim_d;
         lru_q        <= lru_d;
         mem_enable_q <= mem_enable_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
      end
   end

   assign mem_enable_o = mem_enable_q;
   assign mem_write_o  = mem_write_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_data_o   = mem_data_q;

endmodule
